// File: rtl/phase_clock_generator.sv
// Two-phase non-overlapping clock generator with programmable phase length and
// dead time; configuration is double-buffered and swapped only at cycle start.
module phase_clock_generator #(
  parameter int DIV_WIDTH  = 8,
  parameter int DEAD_WIDTH = 4
) (
  input  logic                  CLK_IN,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic                  cfg_valid,
  input  logic [DIV_WIDTH-1:0]  cfg_half,
  input  logic [DEAD_WIDTH-1:0] cfg_dead,
  output logic                  cfg_ack,
  output logic                  clk_1,
  output logic                  clk_2,
  output logic                  CLK_1_OUT,
  output logic                  CLK_2_OUT,
  output logic                  cycle_start
);

  localparam int CW = (DIV_WIDTH > DEAD_WIDTH) ? DIV_WIDTH : DEAD_WIDTH;

  typedef enum logic [2:0] {IDLE, PH1, DEAD12, PH2, DEAD21} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DIV_WIDTH-1:0]  half_a, half_s;
  logic [DEAD_WIDTH-1:0] dead_a, dead_s;
  logic                  expired;

  assign expired   = (cnt == CW'(1));
  assign CLK_1_OUT = clk_1;
  assign CLK_2_OUT = clk_2;

  // Outputs are registered alongside the state: each branch sets the value the
  // outputs must take in the state being entered.
  always_ff @(posedge CLK_IN) begin
    if (RESET) begin
      state       <= IDLE;
      cnt         <= '0;
      clk_1       <= 1'b0;
      clk_2       <= 1'b0;
      cfg_ack     <= 1'b0;
      cycle_start <= 1'b0;
      half_a      <= DIV_WIDTH'(1);
      half_s      <= DIV_WIDTH'(1);
      dead_a      <= DEAD_WIDTH'(1);
      dead_s      <= DEAD_WIDTH'(1);
    end else begin
      cfg_ack     <= cfg_valid;
      cycle_start <= 1'b0;
      if (cfg_valid) begin
        half_s <= (cfg_half == '0) ? DIV_WIDTH'(1) : cfg_half;
        dead_s <= (cfg_dead == '0) ? DEAD_WIDTH'(1) : cfg_dead;
      end
      case (state)
        IDLE: begin
          clk_1 <= 1'b0;
          clk_2 <= 1'b0;
          if (ENABLE) begin
            state       <= PH1;
            half_a      <= half_s;
            dead_a      <= dead_s;
            cnt         <= CW'(half_s);
            clk_1       <= 1'b1;
            cycle_start <= 1'b1;
          end
        end
        PH1: begin
          if (expired) begin
            state <= DEAD12;
            cnt   <= CW'(dead_a);
            clk_1 <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DEAD12: begin
          if (expired) begin
            state <= PH2;
            cnt   <= CW'(half_a);
            clk_2 <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        PH2: begin
          if (expired) begin
            state <= DEAD21;
            cnt   <= CW'(dead_a);
            clk_2 <= 1'b0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        DEAD21: begin
          if (expired) begin
            if (ENABLE) begin
              state       <= PH1;
              half_a      <= half_s;
              dead_a      <= dead_s;
              cnt         <= CW'(half_s);
              clk_1       <= 1'b1;
              cycle_start <= 1'b1;
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          clk_1 <= 1'b0;
          clk_2 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_phase_clock_generator.sv
// Directed and randomized checks of the two-phase clock generator.
module tb_phase_clock_generator;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       cfg_valid;
  logic [7:0] cfg_half;
  logic [3:0] cfg_dead;
  logic       cfg_ack, clk_1, clk_2, clk_1_out, clk_2_out, cycle_start;

  int unsigned checks = 0;
  int unsigned errors = 0;

  phase_clock_generator #(.DIV_WIDTH(8), .DEAD_WIDTH(4)) dut (
    .CLK_IN      (clk),
    .RESET       (rst),
    .ENABLE      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_half    (cfg_half),
    .cfg_dead    (cfg_dead),
    .cfg_ack     (cfg_ack),
    .clk_1       (clk_1),
    .clk_2       (clk_2),
    .CLK_1_OUT   (clk_1_out),
    .CLK_2_OUT   (clk_2_out),
    .cycle_start (cycle_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance one cycle per character; cfg_valid is treated as a one-cycle pulse.
  task automatic run(input string tag, input string s1, input string s2,
                     input string scs, input string sack);
    for (int i = 0; i < s1.len(); i++) begin
      tick();
      cfg_valid = 1'b0;
      check($sformatf("%s[%0d].clk_1", tag, i), 32'(clk_1), 32'(s1[i] == 8'h31));
      check($sformatf("%s[%0d].clk_2", tag, i), 32'(clk_2), 32'(s2[i] == 8'h31));
      check($sformatf("%s[%0d].pad1", tag, i), 32'(clk_1_out), 32'(s1[i] == 8'h31));
      check($sformatf("%s[%0d].pad2", tag, i), 32'(clk_2_out), 32'(s2[i] == 8'h31));
      check($sformatf("%s[%0d].cs", tag, i), 32'(cycle_start), 32'(scs[i] == 8'h31));
      check($sformatf("%s[%0d].ack", tag, i), 32'(cfg_ack), 32'(sack[i] == 8'h31));
    end
  endtask

  task automatic offer(input logic [7:0] h, input logic [3:0] d);
    cfg_valid = 1'b1;
    cfg_half  = h;
    cfg_dead  = d;
  endtask

  initial begin
    logic prev_valid, prev_1, prev_2;
    rst = 1'b1; enable = 1'b0; cfg_valid = 1'b0; cfg_half = '0; cfg_dead = '0;

    // Reset defaults, with ENABLE and cfg_valid asserted to show reset priority
    tick();
    enable = 1'b1;
    offer(8'd7, 4'd7);
    tick();
    check("rst.clk_1", 32'(clk_1), 0);
    check("rst.clk_2", 32'(clk_2), 0);
    check("rst.ack", 32'(cfg_ack), 0);
    check("rst.cs", 32'(cycle_start), 0);
    cfg_valid = 1'b0;
    enable = 1'b0;
    tick();
    rst = 1'b0;

    // Default 1/1/1/1 cycle, then stop
    enable = 1'b1;
    run("dflt", "10001000", "00100010", "10001000", "00000000");
    enable = 1'b0;
    run("stop", "000", "000", "000", "000");

    // half=3 dead=2 written in IDLE, period 10
    offer(8'd3, 4'd2);
    run("cfg32", "00", "00", "00", "10");
    enable = 1'b1;
    run("p10", "11100000001110000000", "00000111000000011100",
        "10000000001000000000", "00000000000000000000");

    // half=5 written during PH2 applies only from the next cycle
    run("mid_a", "111000", "000001", "100000", "000000");
    offer(8'd5, 4'd2);
    run("mid_b", "0000", "1100", "0000", "1000");
    run("p14", "1", "0", "1", "0");

    // ENABLE dropped in the first PH1 cycle: cycle completes, then IDLE
    enable = 1'b0;
    run("drop", "1111000000000000", "0000001111100000",
        "0000000000000000", "0000000000000000");

    // Reset in the 2nd cycle of a half=4 PH1, then re-enable with defaults
    offer(8'd4, 4'd0);
    run("cfg40", "0", "0", "0", "1");
    enable = 1'b1;
    run("ph4", "11", "00", "10", "00");
    rst = 1'b1;
    run("rst_mid", "0", "0", "0", "0");
    rst = 1'b0;
    run("re", "10001000", "00100010", "10001000", "00000000");

    // Zero fields coincide with PH1 entry: old shadow used now, 0 -> 1 after
    offer(8'd0, 4'd0);
    run("zero", "100010001", "001000100", "100010001", "100000000");

    // Randomized configuration and ENABLE
    prev_1 = clk_1;
    prev_2 = clk_2;
    for (int n = 0; n < 10000; n++) begin
      enable    = ($urandom_range(0, 9) != 0);
      cfg_valid = ($urandom_range(0, 9) == 0);
      cfg_half  = 8'($urandom_range(0, 6));
      cfg_dead  = 4'($urandom_range(0, 3));
      prev_valid = cfg_valid;
      tick();
      check("rnd.overlap", 32'(clk_1 & clk_2), 0);
      check("rnd.gap1", 32'(clk_1 & prev_2), 0);
      check("rnd.gap2", 32'(clk_2 & prev_1), 0);
      check("rnd.pad1", 32'(clk_1_out), 32'(clk_1));
      check("rnd.pad2", 32'(clk_2_out), 32'(clk_2));
      check("rnd.ack", 32'(cfg_ack), 32'(prev_valid));
      prev_1 = clk_1;
      prev_2 = clk_2;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
